// File: rtl/exe_stage_if.sv
// Purpose : ID/EX -> EX/MEM signal bundle for the execute stage (operands, control, results).
// Latency : none, wires only.
// Backpress: stall_o travels upstream from the stage to hold ID/EX and earlier stages.
//
// Ports / modports:
//   slave  - the execute stage: consumes the ID/EX fields, drives the EX/MEM fields and stall_o.
//   master - the upstream/downstream environment: drives the ID/EX fields, observes the rest.
interface exe_stage_if;
    // ID/EX side
    logic        in_valid;
    logic        RegDst_in;
    logic        ALUsrc_in;
    logic        Write_reg_mux_in;
    logic        Memwrite_in;
    logic        RegWrite_in;
    logic [1:0]  ALUOp_in;
    logic [31:0] Read_data_1_in;
    logic [31:0] Read_data_2_in;
    logic [31:0] imm_ext_in;
    logic [4:0]  rt_in;
    logic [4:0]  rd_in;

    // Upstream hold request
    logic        stall_o;

    // EX/MEM side
    logic        valid_out;
    logic [31:0] alu_result_out;
    logic [31:0] write_data_out;
    logic [4:0]  write_reg_out;
    logic        Write_reg_mux_out;
    logic        Memwrite_out;
    logic        RegWrite_out;
    logic        zero_out;

    modport slave (
        input  in_valid, RegDst_in, ALUsrc_in, Write_reg_mux_in, Memwrite_in, RegWrite_in,
        input  ALUOp_in, Read_data_1_in, Read_data_2_in, imm_ext_in, rt_in, rd_in,
        output stall_o,
        output valid_out, alu_result_out, write_data_out, write_reg_out,
        output Write_reg_mux_out, Memwrite_out, RegWrite_out, zero_out
    );

    modport master (
        output in_valid, RegDst_in, ALUsrc_in, Write_reg_mux_in, Memwrite_in, RegWrite_in,
        output ALUOp_in, Read_data_1_in, Read_data_2_in, imm_ext_in, rt_in, rd_in,
        input  stall_o,
        input  valid_out, alu_result_out, write_data_out, write_reg_out,
        input  Write_reg_mux_out, Memwrite_out, RegWrite_out, zero_out
    );
endinterface

// File: rtl/exe_stage.sv
// Purpose : pipeline execute stage; add/sub/or in one cycle, 32-bit shift-add multiply (low word).
// Latency : 1 edge for add/sub/or; 33 edges from acceptance for mul (32 MUL iterations).
// Backpress: stall_o holds ID/EX while a mul is being accepted or iterated; drops on the last iteration.
//
// Ports:
//   clk - clock, all state on rising edge
//   rst - synchronous active-high reset, overrides everything (aborts a multiply)
//   ex  - exe_stage_if.slave: ID/EX operands/control in, EX/MEM results/control out, stall_o up
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  ex
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [4:0] CNT_LAST = 5'd31;

    // ------------------------------------------------------------------
    // FSM and multiplier state
    // ------------------------------------------------------------------
    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;

    // Control and destination captured at mul acceptance; the ID/EX
    // inputs are only guaranteed stable, not consumed, while iterating.
    logic        l_wr_mux;
    logic        l_memwrite;
    logic        l_regwrite;
    logic [4:0]  l_write_reg;
    logic [31:0] l_write_data;

    // ------------------------------------------------------------------
    // Operand / destination selection
    // ------------------------------------------------------------------
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  dest;
    logic        is_mul;

    assign op_a   = ex.Read_data_1_in;
    assign op_b   = ex.ALUsrc_in ? ex.imm_ext_in : ex.Read_data_2_in;
    assign dest   = ex.RegDst_in ? ex.rd_in : ex.rt_in;
    assign is_mul = ex.in_valid && (ex.ALUOp_in == OP_MUL);

    // ------------------------------------------------------------------
    // Single-cycle ALU (mul is handled by the iterative datapath)
    // ------------------------------------------------------------------
    logic [31:0] alu_comb;

    always_comb begin
        alu_comb = 32'd0;
        case (ex.ALUOp_in)
            OP_ADD:  alu_comb = op_a + op_b;
            OP_SUB:  alu_comb = op_a - op_b;
            OP_OR:   alu_comb = op_a | op_b;
            default: alu_comb = 32'd0;
        endcase
    end

    // Accumulator value after this cycle's iteration; on the last
    // iteration this is the product that goes straight to EX/MEM.
    logic [31:0] acc_step;

    assign acc_step = acc + (mplier[0] ? mcand : 32'd0);

    // ------------------------------------------------------------------
    // Upstream hold: the accepting cycle of a mul stalls too, so the
    // mul stays in ID/EX until its final iteration; on cnt==31 the stall
    // drops so ID/EX advances on the same edge that emits the product.
    // ------------------------------------------------------------------
    logic stall_comb;

    always_comb begin
        stall_comb = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall_comb = is_mul;
                MUL:     stall_comb = (cnt != CNT_LAST);
                default: stall_comb = 1'b0;
            endcase
        end
    end

    assign ex.stall_o = stall_comb;

    // ------------------------------------------------------------------
    // Sequential: FSM, multiplier iteration, EX/MEM register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            cnt                  <= 5'd0;
            acc                  <= 32'd0;
            mcand                <= 32'd0;
            mplier               <= 32'd0;
            l_wr_mux             <= 1'b0;
            l_memwrite           <= 1'b0;
            l_regwrite           <= 1'b0;
            l_write_reg          <= 5'd0;
            l_write_data         <= 32'd0;
            ex.valid_out         <= 1'b0;
            ex.alu_result_out    <= 32'd0;
            ex.write_data_out    <= 32'd0;
            ex.write_reg_out     <= 5'd0;
            ex.Write_reg_mux_out <= 1'b0;
            ex.Memwrite_out      <= 1'b0;
            ex.RegWrite_out      <= 1'b0;
            ex.zero_out          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ex.in_valid) begin
                        // Bubble: only the side-effecting controls matter downstream.
                        ex.valid_out    <= 1'b0;
                        ex.RegWrite_out <= 1'b0;
                        ex.Memwrite_out <= 1'b0;
                    end else if (is_mul) begin
                        state        <= MUL;
                        cnt          <= 5'd0;
                        acc          <= 32'd0;
                        mcand        <= op_a;
                        mplier       <= op_b;
                        l_wr_mux     <= ex.Write_reg_mux_in;
                        l_memwrite   <= ex.Memwrite_in;
                        l_regwrite   <= ex.RegWrite_in;
                        l_write_reg  <= dest;
                        l_write_data <= ex.Read_data_2_in;
                        ex.valid_out    <= 1'b0;
                        ex.RegWrite_out <= 1'b0;
                        ex.Memwrite_out <= 1'b0;
                    end else begin
                        ex.valid_out         <= 1'b1;
                        ex.alu_result_out    <= alu_comb;
                        ex.zero_out          <= (alu_comb == 32'd0);
                        ex.write_data_out    <= ex.Read_data_2_in;
                        ex.write_reg_out     <= dest;
                        ex.Write_reg_mux_out <= ex.Write_reg_mux_in;
                        ex.Memwrite_out      <= ex.Memwrite_in;
                        ex.RegWrite_out      <= ex.RegWrite_in;
                    end
                end

                MUL: begin
                    acc    <= acc_step;
                    mcand  <= {mcand[30:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
                    cnt    <= cnt + 5'd1;

                    if (cnt == CNT_LAST) begin
                        state                <= IDLE;
                        ex.valid_out         <= 1'b1;
                        ex.alu_result_out    <= acc_step;
                        ex.zero_out          <= (acc_step == 32'd0);
                        ex.write_data_out    <= l_write_data;
                        ex.write_reg_out     <= l_write_reg;
                        ex.Write_reg_mux_out <= l_wr_mux;
                        ex.Memwrite_out      <= l_memwrite;
                        ex.RegWrite_out      <= l_regwrite;
                    end else begin
                        // EX/MEM carries a bubble for every iteration but the last.
                        ex.valid_out    <= 1'b0;
                        ex.RegWrite_out <= 1'b0;
                        ex.Memwrite_out <= 1'b0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    ex.valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Purpose : self-checking bench for exe_stage; a driver models ID/EX, a monitor scores EX/MEM.
// Latency : expected outputs are stamped with the edge at which ID/EX advances.
// Backpress: the driver holds each vector while stall_o is high and counts stalled cycles.
module tb_exe_stage;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    exe_stage_if bus ();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable around the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        valid;
        logic        regdst;
        logic        alusrc;
        logic        wr_mux;
        logic        memwr;
        logic        regwr;
        logic [1:0]  op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic [4:0]  exp_wreg;
        int          exp_stall;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        bubble;
        logic [31:0] res;
        logic        zero;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        wr_mux;
        logic        memwr;
        logic        regwr;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: score EX/MEM on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("valid_out", {31'd0, bus.valid_out}, {31'd0, !e.bubble});
            check("RegWrite_out", {31'd0, bus.RegWrite_out}, {31'd0, e.regwr});
            check("Memwrite_out", {31'd0, bus.Memwrite_out}, {31'd0, e.memwr});
            if (!e.bubble) begin
                check("alu_result_out", bus.alu_result_out, e.res);
                check("zero_out", {31'd0, bus.zero_out}, {31'd0, e.zero});
                check("write_reg_out", {27'd0, bus.write_reg_out}, {27'd0, e.wreg});
                check("write_data_out", bus.write_data_out, e.wdata);
                check("Write_reg_mux_out", {31'd0, bus.Write_reg_mux_out}, {31'd0, e.wr_mux});
            end
        end else if (bus.valid_out === 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: valid_out=1 with no expected result at cycle %0d (result 0x%08h)",
                     cyc, bus.alu_result_out);
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic apply(input vec_t v);
        bus.in_valid         = v.valid;
        bus.RegDst_in        = v.regdst;
        bus.ALUsrc_in        = v.alusrc;
        bus.Write_reg_mux_in = v.wr_mux;
        bus.Memwrite_in      = v.memwr;
        bus.RegWrite_in      = v.regwr;
        bus.ALUOp_in         = v.op;
        bus.Read_data_1_in   = v.rd1;
        bus.Read_data_2_in   = v.rd2;
        bus.imm_ext_in       = v.imm;
        bus.rt_in            = v.rt;
        bus.rd_in            = v.rd;
    endtask

    // Called at a falling edge; returns at the next falling edge after ID/EX advances.
    task automatic issue(input vec_t v, input string name);
        int   stalls;
        int   edge_no;
        logic s;
        logic done;
        exp_t e;
        stalls = 0;
        done   = 1'b0;
        edge_no = 0;
        apply(v);
        for (int k = 0; k < 64; k++) begin
            #1;
            s       = bus.stall_o;
            edge_no = cyc + 1;
            @(posedge clk);
            if (!s) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: stall_o still high after %0d cycles, expected release", name, stalls);
            @(negedge clk);
        end else begin
            check({name, "_stall_cycles"}, stalls, v.exp_stall);
            e.cyc    = edge_no;
            e.bubble = !v.valid;
            e.res    = v.exp_res;
            e.zero   = v.exp_zero;
            e.wreg   = v.exp_wreg;
            e.wdata  = v.rd2;
            e.wr_mux = v.wr_mux;
            e.memwr  = v.valid ? v.memwr : 1'b0;
            e.regwr  = v.valid ? v.regwr : 1'b0;
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid_out"}, {31'd0, bus.valid_out}, 32'd0);
        check({name, "_alu_result"}, bus.alu_result_out, 32'd0);
        check({name, "_write_data"}, bus.write_data_out, 32'd0);
        check({name, "_write_reg"}, {27'd0, bus.write_reg_out}, 32'd0);
        check({name, "_ctl"}, {28'd0, bus.Write_reg_mux_out, bus.Memwrite_out, bus.RegWrite_out, bus.zero_out}, 32'd0);
        check({name, "_stall"}, {31'd0, bus.stall_o}, 32'd0);
    endtask

    // Directed vectors with hand-computed results:
    // valid regdst alusrc wrmux memwr regwr op rd1 rd2 imm rt rd | res zero wreg stall
    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0005, 32'h0000_AAAA, 32'hFFFF_FFFF, 5'd3, 5'd9,
                    32'h0000_0004, 1'b0, 5'd3, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 5'd2, 5'd7,
                    32'h0000_0000, 1'b1, 5'd7, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 32'hF0F0_0000, 32'h0000_0F0F, 32'h1111_1111, 5'd12, 5'd1,
                    32'hF0F0_0F0F, 1'b0, 5'd12, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 5'd4, 5'd31,
                    32'hFFFF_FFFE, 1'b0, 5'd31, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0001_0001, 32'h0001_0001, 32'h0000_0000, 5'd5, 5'd10,
                    32'h0002_0001, 1'b0, 5'd10, 32};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 32'h0000_0003, 32'h0000_0007, 32'h0000_0000, 5'd6, 5'd11,
                    32'h0000_0015, 1'b0, 5'd6, 32};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0001, 32'h0000_00C3, 32'h0000_0001, 5'd8, 5'd13,
                    32'h0000_0002, 1'b0, 5'd13, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0000_0002, 5'd14, 5'd15,
                    32'hFFFF_FFFE, 1'b0, 5'd14, 32};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 5'd1, 5'd2,
                    32'h0000_0012, 1'b0, 5'd1, 0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd20, 5'd21,
                    32'h0000_0000, 1'b1, 5'd20, 0};
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int   n;
        logic s;
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;

        // Reset with a mul presented: stall_o must stay low while rst is high.
        rst = 1'b1;
        apply(vecs[4]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i], $sformatf("vec%0d", i));
        end

        // Drain, then abort a multiply with reset after 10 iterations.
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);

        apply(vecs[5]);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            #1;
            s = bus.stall_o;
            @(posedge clk);
            if (s) n++;
            if (n == 11 || !s) break;
            @(negedge clk);
        end
        check("abort_stalled_edges", n, 11);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("abort_stall_in_reset", {31'd0, bus.stall_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("abort");
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // A fresh add after the abort must still work normally.
        issue(vecs[0], "post_abort");
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL have port in_valid  in  1  instruction present at ID/EX outputs this cycle.
REQ-004 SHALL have ports RegDst_in, ALUsrc_in, Write_reg_mux_in, Memwrite_in, RegWrite_in  in  1 each  ID/EX control bits.
REQ-005 SHALL have port ALUOp_in  in  2  operation: 00 add, 01 sub, 10 or, 11 mul (low 32 bits).
REQ-006 SHALL have ports Read_data_1_in, Read_data_2_in, imm_ext_in  in  32 each  operands from ID/EX.
REQ-007 SHALL have ports rt_in, rd_in  in  5 each  destination candidates.
REQ-008 SHALL have port stall_o  out  1  hold ID/EX and earlier stages this cycle.
REQ-009 SHALL have port valid_out  out  1  EX/MEM entry holds a real instruction.
REQ-010 SHALL have ports alu_result_out, write_data_out  out  32 each  ALU result; store data (Read_data_2).
REQ-011 SHALL have port write_reg_out  out  5  selected destination register.
REQ-012 SHALL have ports Write_reg_mux_out, Memwrite_out, RegWrite_out, zero_out  out  1 each  forwarded control; alu_result==0.

Function
REQ-013 SHALL select operand B = ALUsrc_in ? imm_ext_in : Read_data_2_in; operand A = Read_data_1_in.
REQ-014 SHALL select destination = RegDst_in ? rd_in : rt_in.
REQ-015 SHALL compute add/sub/or modulo 2^32, no overflow detection or trap.
REQ-016 SHALL implement FSM with states IDLE and MUL, plus a 5-bit iteration counter cnt.
REQ-017 SHALL, in IDLE with in_valid=1 and ALUOp!=11, register all outputs at the next edge with valid_out=1 (latency 1, no stall).
REQ-018 SHALL, in IDLE with in_valid=0, register valid_out=0, RegWrite_out=0, Memwrite_out=0 at the next edge (bubble; other outputs don't-care).
REQ-019 SHALL, in IDLE with in_valid=1 and ALUOp=11, drive stall_o=1 combinationally, and at the edge load multiplicand=A, multiplier=B, acc=0, cnt=0, latch control and destination, enter MUL, register valid_out=0.
REQ-020 SHALL, on each edge in MUL, add multiplicand to acc when multiplier[0]=1, shift multiplicand left 1, shift multiplier right 1, increment cnt.
REQ-021 SHALL drive stall_o=1 in MUL while cnt!=31 and stall_o=0 when cnt=31.
REQ-022 SHALL, at the MUL edge with cnt=31, register alu_result_out = final acc (A*B mod 2^32) and latched control with valid_out=1, and return to IDLE; total 33 edges from acceptance, 32 cycles of stall.
REQ-023 SHALL ignore input values in MUL other than requiring upstream to hold them; the instruction following a mul is accepted in IDLE on the edge after the result edge.
REQ-024 SHALL register valid_out=0 on every MUL edge with cnt!=31 (EX/MEM bubble during multiply).
REQ-025 SHALL compute zero_out from the value registered into alu_result_out in the same edge.
REQ-026 SHALL pass write_data_out = Read_data_2_in regardless of ALUsrc_in (latched value for mul).

Reset
REQ-027 SHALL on rst=1 at an edge set state IDLE, cnt=0, acc=0, all 32-bit outputs 0, write_reg_out 0, all 1-bit outputs 0, valid_out 0.
REQ-028 SHALL give rst priority over all activity, aborting an in-progress multiply with no result ever emitted.
REQ-029 SHALL drive stall_o=0 while rst=1.

Verification
REQ-030 SHALL cover add: A=5, imm=0xFFFFFFFF, ALUsrc=1, ALUOp=00 -> next edge alu_result=4, zero=0, valid_out=1, stall_o never 1.
REQ-031 SHALL cover sub to zero: A=B=0x1234, ALUOp=01, RegDst=1, rd=7 -> alu_result=0, zero_out=1, write_reg_out=7.
REQ-032 SHALL cover mul: A=0x10001, B=0x10001, ALUOp=11 -> stall_o high 32 cycles, valid_out=0 for 32 edges, then alu_result=0x00020001, valid_out=1 one cycle.
REQ-033 SHALL cover back-to-back: mul 3*7 then add 1+1 held by stall -> results 21 then 2 on consecutive valid_out cycles, no instruction lost or duplicated.
REQ-034 SHALL cover reset mid-multiply: rst at cnt=10 -> next edge all outputs 0, state IDLE, stall_o=0, no mul result emitted afterwards.
REQ-035 SHALL cover bubble: in_valid=0 with RegWrite_in=1, Memwrite_in=1 -> valid_out=0, RegWrite_out=0, Memwrite_out=0.
